bit_stream_serializer: RTL and testbench
========================================

Name: bit_stream_serializer

Overview:
Upstream stage for the snail pattern-detector FSMs. Accepts a parallel word over a valid/ready handshake and emits it MSB-first as a serial bit `a`, qualified by a one-cycle enable strobe `en` at a programmable period. Outputs `a` and `en` connect directly to the detector's `a`/`en` inputs, so the detector steps exactly once per emitted bit.

Parameters:
W, 8, word width in bits (W >= 2)
DIV_W, 24, width of the strobe period input

Ports:
clk  input  1  system clock
rst  input  1  reset
period  input  DIV_W  cycles per bit; 0 is treated as 1
word_valid  input  1  upstream offers word_data
word_ready  output  1  block can accept a word
word_data  input  W  word to serialize, MSB sent first
a  output  1  current serial bit
en  output  1  one-cycle strobe; `a` is valid for the consumer on this cycle
busy  output  1  a word is being shifted out
word_done  output  1  one-cycle pulse after the last bit of a word

Behaviour:
- One clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state IDLE, a=0, en=0, busy=0, word_done=0, word_ready=1, internal counters 0, shift register 0.
- States: IDLE and SHIFT.
- IDLE:
  - word_ready=1, busy=0, a=0, en=0.
  - On word_valid&&word_ready: load shreg=word_data, bits_left=W, tick counter=0; next state SHIFT.
- SHIFT:
  - word_ready=0, busy=1.
  - a = shreg[W-1], held stable between ticks.
- Tick counter:
  - Counts only in SHIFT; held at 0 in IDLE.
  - tick = (cnt >= eff_period-1), where eff_period = (period==0) ? 1 : period.
  - On tick, cnt wraps to 0; otherwise cnt+1.
  - `period` is sampled live every cycle. Using `>=` guarantees a shortened period mid-word never stalls.
- en = tick && (state==SHIFT). It is purely one cycle wide.
- On tick in SHIFT:
  - shreg shifts left by 1 (zero fill); bits_left decrements.
  - If bits_left==1, next state is IDLE and word_done=1 in the following cycle (registered).
- Timing with the load edge at end of cycle 0:
  - Bit k (k=0..W-1, MSB=0) is strobed in cycle (k+1)*eff_period.
  - word_done and word_ready are both high in cycle W*eff_period+1.
  - Earliest next load is accepted in that same cycle, so there is a minimum 1-cycle bubble between words.
- word_valid during SHIFT is ignored (ready=0). Upstream must hold data until accepted.
- word_data is captured only at acceptance. Later changes to it do not affect the word in flight.
- Reset mid-word: the in-flight word is discarded, all outputs take reset values in the next cycle, and no word_done is produced.
- Width rules: bits_left is $clog2(W+1) bits; cnt is DIV_W bits. No arithmetic overflow is possible because cnt wraps at most at eff_period-1.

Decomposition:
- Package bit_stream_pkg holds:
  - the state enum (IDLE, SHIFT) as typedef ser_state_e;
  - localparam DEFAULT_W=8 and DEFAULT_DIV_W=24.
- Sub-module bit_strobe_gen contains the tick counter.
  - Ports: clk, rst, run, period, tick.
  - Counter clears when run=0.
  - Reusable for other labs that need slow enable strobes.

Test Plan:
1. period=1, load 8'hB0 -> en high cycles 1..8, a sequence 1,0,1,1,0,0,0,0; word_done in cycle 9; word_ready low cycles 1..8.
2. period=3, load 8'h81 -> en in cycles 3,6,...,24 only, a=1 at cycles 3 and 24 and 0 at the other strobes; a stable between strobes; word_done in cycle 25.
3. period=0 -> identical behaviour to period=1 (scenario 1 re-run with period=0).
4. Back-to-back: word_valid held high with 8'hFF then 8'h00, period=1 -> second word accepted in cycle 9 (the word_done cycle); its first strobe is in cycle 10; no bit lost or duplicated.
5. Reset mid-word: period=2, assert rst in cycle 7 for 1 cycle -> next cycle en=0, a=0, busy=0, word_ready=1; no word_done pulse; a fresh word afterwards serializes correctly.
6. System check: serializer drives a downstream snail pattern FSM with period=4 and words containing the target pattern -> detector output asserts at the expected strobe counts; scoreboard compares against a bit-level reference model.

Source files
------------

// File: rtl/bit_stream_pkg.sv
// Shared types and default sizes for the bit-stream serializer slice.
package bit_stream_pkg;

  localparam int unsigned DEFAULT_W     = 8;
  localparam int unsigned DEFAULT_DIV_W = 24;

  typedef enum logic {
    IDLE,
    SHIFT
  } ser_state_e;

endpackage

// File: rtl/bit_strobe_gen.sv
// Programmable-period enable strobe. While run is high, tick fires once every
// max(period,1) cycles; the counter is held at zero while run is low.
module bit_strobe_gen
  import bit_stream_pkg::*;
#(
  parameter int unsigned DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;

  // Terminal count; period 0 behaves like period 1. Comparing with >= lets a
  // period shortened mid-count fire on the next cycle instead of wrapping.
  always_comb begin
    last = (period == '0) ? '0 : period - DIV_W'(1);
    tick = run && (cnt >= last);
  end

  // Free-running counter, cleared when idle and on every tick.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial converter: accepts a word over valid/ready and shifts it
// out MSB-first on `a`, one bit per `en` strobe, pulsing word_done at the end.
module bit_stream_serializer
  import bit_stream_pkg::*;
#(
  parameter int unsigned W     = DEFAULT_W,
  parameter int unsigned DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] period,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic [W-1:0]     word_data,
  output logic             a,
  output logic             en,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned BL_W = $clog2(W + 1);

  ser_state_e      state;
  logic [W-1:0]    shreg;
  logic [BL_W-1:0] bits_left;
  logic            tick;

  bit_strobe_gen #(
    .DIV_W (DIV_W)
  ) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .run    (state == SHIFT),
    .period (period),
    .tick   (tick)
  );

  // Handshake and serial outputs decoded from the state register.
  always_comb begin
    word_ready = (state == IDLE);
    busy       = (state == SHIFT);
    en         = tick && (state == SHIFT);
    a          = (state == SHIFT) && shreg[W-1];
  end

  // Load / shift control with registered end-of-word pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bits_left <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      case (state)
        IDLE: begin
          if (word_valid) begin
            shreg     <= word_data;
            bits_left <= BL_W'(W);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            shreg     <= {shreg[W-2:0], 1'b0};
            bits_left <= bits_left - BL_W'(1);
            if (bits_left == BL_W'(1)) begin
              state     <= IDLE;
              word_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Self-checking bench for bit_stream_serializer with an arithmetic timing
// model and a downstream "1101" pattern detector as the system consumer.
module tb_bit_stream_serializer;

  localparam int unsigned W     = 8;
  localparam int unsigned DIV_W = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic [DIV_W-1:0] period;
  logic             word_valid;
  logic             word_ready;
  logic [W-1:0]     word_data;
  logic             a;
  logic             en;
  logic             busy;
  logic             word_done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  bit_stream_serializer #(
    .W     (W),
    .DIV_W (DIV_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .period     (period),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .a          (a),
    .en         (en),
    .busy       (busy),
    .word_done  (word_done)
  );

  always #5 clk = ~clk;

  // Downstream consumer: overlapping "1101" detector stepping once per en.
  typedef enum logic [1:0] {D0, D1, D11, D110} det_e;
  det_e det_st;
  logic det_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      det_st <= D0;
    end else if (en) begin
      case (det_st)
        D0:      det_st <= a ? D1  : D0;
        D1:      det_st <= a ? D11 : D0;
        D11:     det_st <= a ? D11 : D110;
        D110:    det_st <= a ? D1  : D0;
        default: det_st <= D0;
      endcase
    end
  end

  always_comb det_hit = en && (det_st == D110) && a;

  // Reference bit history for the detector check.
  logic ref_bits[$];

  // Expected {en,a,word_done,word_ready,busy} in cycle c after a load at the
  // end of cycle 0, for word w and period p.
  function automatic logic [4:0] model(input logic [W-1:0] w, input int unsigned p,
                                       input int unsigned c);
    int unsigned ep;
    int unsigned last;
    int unsigned idx;
    ep   = (p == 0) ? 1 : p;
    last = W * ep;
    if (c >= 1 && c <= last) begin
      idx = (c - 1) / ep;
      return {((c % ep) == 0), w[W-1-idx], 1'b0, 1'b0, 1'b1};
    end else if (c == last + 1) begin
      return 5'b00110;
    end
    return 5'b00010;
  endfunction

  function automatic logic [4:0] obs();
    return {en, a, word_done, word_ready, busy};
  endfunction

  // Serializes one word starting at the current negedge (cycle 0) and checks
  // every cycle through word_done, plus one trailing idle cycle.
  task automatic run_word(input string name, input logic [W-1:0] w,
                          input int unsigned p, input bit sys);
    int unsigned ep;
    logic [4:0]  exp;
    logic        ref_hit;
    ep         = (p == 0) ? 1 : p;
    period     = DIV_W'(p);
    word_data  = w;
    word_valid = 1'b1;
    checks++;
    if (obs() !== model(w, p, 0)) begin
      errors++;
      $display("FAIL %s c=0 got=%b exp=%b", name, obs(), model(w, p, 0));
    end
    for (int unsigned c = 1; c <= W * ep + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        word_valid = 1'b0;
        word_data  = W'($urandom);
      end
      exp = model(w, p, (c == W * ep + 2) ? 0 : c);
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL %s c=%0d got=%b exp=%b", name, c, obs(), exp);
      end
      if (sys) begin
        ref_hit = 1'b0;
        if (exp[4]) begin
          ref_bits.push_back(exp[3]);
          if (ref_bits.size() >= 4)
            ref_hit = {ref_bits[$-3], ref_bits[$-2], ref_bits[$-1], ref_bits[$]} == 4'b1101;
        end
        checks++;
        if (det_hit !== ref_hit) begin
          errors++;
          $display("FAIL %s_detect c=%0d bit#%0d got=%b exp=%b", name, c,
                   ref_bits.size(), det_hit, ref_hit);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    word_valid = 1'b0;
    word_data  = '0;
    period     = DIV_W'(1);
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== 5'b00010) begin
      errors++;
      $display("FAIL reset got=%b exp=%b", obs(), 5'b00010);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_period1();
    run_word("period1", 8'hB0, 1, 1'b0);
  endtask

  task automatic test_period3();
    run_word("period3", 8'h81, 3, 1'b0);
  endtask

  task automatic test_period0();
    run_word("period0", 8'hB0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_word("random", W'($urandom), $urandom_range(0, 4), 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp;
    logic [15:0] got_bits;
    int unsigned nbits;
    got_bits   = '0;
    nbits      = 0;
    period     = DIV_W'(1);
    word_data  = 8'hFF;
    word_valid = 1'b1;
    for (int unsigned c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c <= 9) exp = model(8'hFF, 1, c);
      else        exp = model(8'h00, 1, (c == 19) ? 0 : c - 9);
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL back_to_back c=%0d got=%b exp=%b", c, obs(), exp);
      end
      if (en) begin
        got_bits = {got_bits[14:0], a};
        nbits++;
      end
      if (c == 9)  word_data  = 8'h00;
      if (c == 10) word_valid = 1'b0;
    end
    checks++;
    if (nbits != 16 || got_bits !== 16'hFF00) begin
      errors++;
      $display("FAIL back_to_back_stream got=%0d bits %h exp=16 bits ff00", nbits, got_bits);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [W-1:0] w;
    w          = W'($urandom);
    period     = DIV_W'(2);
    word_data  = w;
    word_valid = 1'b1;
    for (int unsigned c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) word_valid = 1'b0;
      checks++;
      if (c <= 7) begin
        if (obs() !== model(w, 2, c)) begin
          errors++;
          $display("FAIL reset_mid c=%0d got=%b exp=%b", c, obs(), model(w, 2, c));
        end
      end else if (obs() !== 5'b00010) begin
        errors++;
        $display("FAIL reset_mid_idle c=%0d got=%b exp=%b", c, obs(), 5'b00010);
      end
      if (c == 7) rst = 1'b1;
      if (c == 8) rst = 1'b0;
    end
    run_word("after_reset", W'($urandom), 2, 1'b0);
  endtask

  task automatic test_system();
    logic [W-1:0] w;
    int unsigned  pos;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ref_bits.delete();
    for (int i = 0; i < 5; i++) begin
      w   = W'($urandom);
      pos = $urandom_range(0, W - 4);
      w[pos+:4] = 4'b1101;
      run_word("system", w, 4, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_period1();
    test_period3();
    test_period0();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
    test_system();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
